// File: rtl/lifm_line_generator.sv
// Walks a single-channel IFM in SRAM and emits one lowered-IFM line (MAX_R_SIZE lanes) per weight index,
// output-position tiles outer, weight index inner; one line per MAX_R_SIZE+2 cycles when never stalled.
module lifm_line_generator #(
  parameter int WORD_WIDTH = 8,
  parameter int MAX_R_SIZE = 4,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [WORD_WIDTH-1:0]            iw,
  input  logic [WORD_WIDTH-1:0]            ow,
  input  logic [WORD_WIDTH-1:0]            oh,
  input  logic [WORD_WIDTH-1:0]            fw,
  input  logic [WORD_WIDTH-1:0]            fh,
  input  logic [WORD_WIDTH-1:0]            st,
  output logic                             mem_rd_en,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [WORD_WIDTH-1:0]            mem_rdata,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [MAX_R_SIZE*WORD_WIDTH-1:0] lifm_line,
  output logic [WORD_WIDTH-1:0]            idx,
  output logic                             busy,
  output logic                             done
);

  localparam int WW  = WORD_WIDTH;
  localparam int AW  = ADDR_WIDTH;
  localparam int R   = MAX_R_SIZE;
  localparam int PW  = 2 * WORD_WIDTH + 1;
  localparam int FCW = $clog2(MAX_R_SIZE + 1);
  localparam logic [WW-1:0] ONE_W = WW'(1);

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

  state_t          state;
  logic [WW-1:0]   iw_r, ow_r, oh_r, fw_r, fh_r, st_r;
  logic [PW-1:0]   total_r, tile_base, lane_p;
  logic [WW-1:0]   tile_x, tile_y, lane_x, lane_y, kh, kw;
  logic [FCW-1:0]  fc;
  logic            rd_pend;

  logic            last_kw, last_idx, last_tile;
  logic [WW-1:0]   nx_kh, nx_kw, nx_tx, nx_ty;
  logic [PW-1:0]   nx_base;

  function automatic logic [AW-1:0] addr_of(input logic [WW-1:0] y, x, h, w);
    addr_of = (AW'(y) * AW'(st_r) + AW'(h)) * AW'(iw_r) + AW'(x) * AW'(st_r) + AW'(w);
  endfunction

  // Raster step of an output position with wrap at the output width; returns {y, x}.
  function automatic logic [2*WW-1:0] step_pos(input logic [WW-1:0] x, y, w);
    if (x == w - ONE_W) step_pos = {y + ONE_W, {WW{1'b0}}};
    else                step_pos = {y, x + ONE_W};
  endfunction

  assign last_kw   = (kw == fw_r - ONE_W);
  assign last_idx  = last_kw && (kh == fh_r - ONE_W);
  assign last_tile = (tile_base + PW'(R) >= total_r);

  // After a FETCH the lane walker sits on tile_base+R, which is the origin of the next tile.
  always_comb begin
    nx_kh   = kh;
    nx_kw   = kw + ONE_W;
    nx_tx   = tile_x;
    nx_ty   = tile_y;
    nx_base = tile_base;
    if (last_kw) begin
      nx_kw = '0;
      nx_kh = kh + ONE_W;
    end
    if (last_idx) begin
      nx_kh   = '0;
      nx_tx   = lane_x;
      nx_ty   = lane_y;
      nx_base = tile_base + PW'(R);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      iw_r      <= '0;
      ow_r      <= '0;
      oh_r      <= '0;
      fw_r      <= '0;
      fh_r      <= '0;
      st_r      <= '0;
      total_r   <= '0;
      tile_base <= '0;
      lane_p    <= '0;
      tile_x    <= '0;
      tile_y    <= '0;
      lane_x    <= '0;
      lane_y    <= '0;
      kh        <= '0;
      kw        <= '0;
      fc        <= '0;
      rd_pend   <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      lifm_line <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_pend <= mem_rd_en;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            iw_r      <= iw;
            ow_r      <= ow;
            oh_r      <= oh;
            fw_r      <= fw;
            fh_r      <= fh;
            st_r      <= st;
            total_r   <= PW'(ow) * PW'(oh);
            kh        <= '0;
            kw        <= '0;
            idx       <= '0;
            tile_base <= '0;
            tile_x    <= '0;
            tile_y    <= '0;
            busy      <= 1'b1;
            if (ow == '0 || oh == '0 || fw == '0 || fh == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              // Position (0,0) with kh=kw=0 always maps to address 0.
              state            <= FETCH;
              fc               <= '0;
              mem_rd_en        <= 1'b1;
              mem_addr         <= '0;
              {lane_y, lane_x} <= step_pos('0, '0, ow);
              lane_p           <= PW'(1);
            end
          end
        end
        FETCH: begin
          for (int j = 0; j < R; j++) begin
            if (int'(fc) == j + 1) lifm_line[j*WW +: WW] <= rd_pend ? mem_rdata : '0;
          end
          if (int'(fc) + 1 < R) begin
            mem_rd_en        <= (lane_p < total_r);
            mem_addr         <= addr_of(lane_y, lane_x, kh, kw);
            {lane_y, lane_x} <= step_pos(lane_x, lane_y, ow_r);
            lane_p           <= lane_p + PW'(1);
          end else begin
            mem_rd_en <= 1'b0;
          end
          if (int'(fc) == R) begin
            state     <= EMIT;
            out_valid <= 1'b1;
          end
          fc <= fc + FCW'(1);
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_idx && last_tile) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              kh               <= nx_kh;
              kw               <= nx_kw;
              idx              <= last_idx ? '0 : idx + ONE_W;
              tile_base        <= nx_base;
              tile_x           <= nx_tx;
              tile_y           <= nx_ty;
              state            <= FETCH;
              fc               <= '0;
              mem_rd_en        <= 1'b1;
              mem_addr         <= addr_of(nx_ty, nx_tx, nx_kh, nx_kw);
              {lane_y, lane_x} <= step_pos(nx_tx, nx_ty, ow_r);
              lane_p           <= nx_base + PW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lifm_line_generator.sv
// Directed and randomized bench for lifm_line_generator with a positional reference model and SRAM model.
module tb_lifm_line_generator;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  iw, ow, oh, fw, fh, st;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] lifm_line;
  logic [7:0]  idx;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  logic [7:0]  mem [0:65535];
  logic [31:0] obs_line [$];

  lifm_line_generator #(.WORD_WIDTH(8), .MAX_R_SIZE(R), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .iw(iw), .ow(ow), .oh(oh), .fw(fw), .fh(fh), .st(st),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .lifm_line(lifm_line), .idx(idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_pass(input int a_iw, a_ow, a_oh, a_fw, a_fh, a_st,
                          input int mode, input bit poke, output int reads_o);
    logic [31:0] exp_q [$];
    logic [7:0]  eidx_q [$];
    logic [31:0] line;
    logic [31:0] held_line;
    logic [7:0]  held_idx;
    int total, reads_exp, reads, n, lines_exp, wait_left, done_n;
    bit held;
    total = a_ow * a_oh;
    reads_exp = 0; reads = 0; n = 0; wait_left = 5; done_n = -1; held = 0;
    held_line = '0; held_idx = '0;
    if (a_ow > 0 && a_oh > 0 && a_fw > 0 && a_fh > 0) begin
      for (int tb = 0; tb < total; tb += R)
        for (int kh = 0; kh < a_fh; kh++)
          for (int kw = 0; kw < a_fw; kw++) begin
            line = '0;
            for (int j = 0; j < R; j++) begin
              if (tb + j < total) begin
                int p, oy, ox, a;
                p  = tb + j;
                oy = p / a_ow;
                ox = p % a_ow;
                a  = ((oy * a_st + kh) * a_iw + ox * a_st + kw) % 65536;
                line[j*8 +: 8] = mem[a];
                reads_exp++;
              end
            end
            exp_q.push_back(line);
            eidx_q.push_back(8'(kh * a_fw + kw));
          end
    end
    lines_exp = exp_q.size();
    obs_line.delete();

    @(negedge clk);
    iw = 8'(a_iw); ow = 8'(a_ow); oh = 8'(a_oh); fw = 8'(a_fw); fh = 8'(a_fh); st = 8'(a_st);
    start = 1'b1;
    out_ready = 1'b1;
    while (done_n < 0 && n < 4000) begin
      @(negedge clk);
      n++;
      if (mem_rd_en) begin
        reads++;
        chk("rd_during_emit", 64'(out_valid), 64'd0);
      end
      if (held) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_line", 64'(lifm_line), 64'(held_line));
        chk("hold_idx", 64'(idx), 64'(held_idx));
      end else if (out_valid) begin
        if (exp_q.size() == 0) chk("extra_line", 64'(out_valid), 64'd0);
        else begin
          chk("line", 64'(lifm_line), 64'(exp_q.pop_front()));
          chk("idx", 64'(idx), 64'(eidx_q.pop_front()));
        end
        obs_line.push_back(lifm_line);
      end
      start = 1'b0;
      if (n == 1) begin
        iw = 8'($urandom); ow = 8'($urandom); oh = 8'($urandom);
        fw = 8'($urandom); fh = 8'($urandom); st = 8'($urandom);
      end
      if (poke && n == 3) begin
        start = 1'b1;
        ow = 8'd0;
      end
      if (done) done_n = n;
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2 && out_valid && wait_left > 0) begin
        out_ready = 1'b0;
        wait_left--;
      end else out_ready = 1'b1;
      held = out_valid && !out_ready;
      held_line = lifm_line;
      held_idx = idx;
    end
    if (done_n < 0) chk("timeout_done", 64'(done), 64'd1);
    chk("lines_left", 64'(exp_q.size()), 64'd0);
    chk("read_count", 64'(reads), 64'(reads_exp));
    if (mode == 0) chk("done_cycle", 64'(done_n), 64'(lines_exp * (R + 2) + 1));

    // A start coinciding with done must be ignored.
    iw = 8'd4; ow = 8'd2; oh = 8'd2; fw = 8'd1; fh = 8'd1; st = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("start_in_done_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("start_in_done_rd", 64'(mem_rd_en), 64'd0);
    chk("start_in_done_busy2", 64'(busy), 64'd0);
    reads_o = reads;
  endtask

  initial begin
    int rd, dn, rw, rh, rfw, rfh, rst_;
    logic [31:0] ln;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; mem_rdata = '0;
    iw = '0; ow = '0; oh = '0; fw = '0; fh = '0; st = '0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a);
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_line", 64'(lifm_line), 64'd0);
    chk("rst_idx", 64'(idx), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_pass(4, 2, 2, 3, 3, 1, 0, 0, rd);
    chk("t1_lines", 64'(obs_line.size()), 64'd9);
    ln = '1; if (obs_line.size() > 4) ln = obs_line[4];
    chk("t1_idx4_lanes", 64'(ln), 64'h0A090605);

    run_pass(5, 2, 2, 2, 2, 2, 0, 0, rd);
    ln = '1; if (obs_line.size() > 0) ln = obs_line[0];
    chk("t2_idx0_lanes", 64'(ln), 64'h0C0A0200);
    ln = '1; if (obs_line.size() > 3) ln = obs_line[3];
    chk("t2_idx3_lanes", 64'(ln), 64'h12100806);

    run_pass(4, 3, 1, 2, 1, 1, 0, 0, rd);
    chk("t3_reads", 64'(rd), 64'd6);
    ln = '1; if (obs_line.size() > 0) ln = obs_line[0];
    chk("t3_line0", 64'(ln), 64'h00020100);
    ln = '1; if (obs_line.size() > 1) ln = obs_line[1];
    chk("t3_line1", 64'(ln), 64'h00030201);

    run_pass(4, 2, 2, 3, 3, 1, 2, 0, rd);
    chk("bp_lines", 64'(obs_line.size()), 64'd9);

    run_pass(4, 2, 2, 0, 3, 1, 0, 0, rd);
    chk("deg_fw_reads", 64'(rd), 64'd0);
    run_pass(4, 2, 0, 2, 2, 1, 0, 0, rd);
    chk("deg_oh_reads", 64'(rd), 64'd0);

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int t = 0; t < 8; t++) begin
      rw = $urandom_range(1, 5); rh = $urandom_range(1, 4);
      rfw = $urandom_range(1, 3); rfh = $urandom_range(1, 3); rst_ = $urandom_range(1, 2);
      run_pass((rw - 1) * rst_ + rfw + $urandom_range(0, 2), rw, rh, rfw, rfh, rst_,
               (t % 3 == 2) ? 0 : 1, (t % 2) == 1, rd);
    end

    // Reset in the middle of a FETCH aborts the pass without a done pulse.
    @(negedge clk);
    iw = 8'd4; ow = 8'd2; oh = 8'd2; fw = 8'd3; fh = 8'd3; st = 8'd1;
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (80) begin
      @(negedge clk);
      if (done || out_valid || mem_rd_en) dn++;
    end
    chk("midrst_no_activity", 64'(dn), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
